sdram_refresh_sched: RTL

SDRAM_REFRESH_SCHED -- requirements
Module: sdram_refresh_sched

---
 rtl/sdram_refresh_sched_if.sv | 22 ++
 rtl/sdram_refresh_sched.sv | 105 ++++++++++
 2 files changed

// File: rtl/sdram_refresh_sched_if.sv
// Signals between the SDRAM refresh scheduler (master) and the SDRAM controller side (slave).
interface sdram_refresh_sched_if;
  logic       init_done;
  logic       ram_cycle;
  logic       cmd_idle;
  logic       ref_ack;
  logic       ref_req;
  logic       ref_urgent;
  logic [3:0] pending;
  logic       overflow;

  // Handshake: ref_req rises and stays high until the controller returns a one-cycle
  // ref_ack; that ack retires one owed refresh. An ack while ref_req is low is ignored.
  modport master (
    input  init_done, ram_cycle, cmd_idle, ref_ack,
    output ref_req, ref_urgent, pending, overflow
  );
  modport slave (
    output init_done, ram_cycle, cmd_idle, ref_ack,
    input  ref_req, ref_urgent, pending, overflow
  );
endinterface

// File: rtl/sdram_refresh_sched.sv
// SDRAM auto-refresh scheduler: counts owed refreshes per interval and requests them when the bus allows.
// Define REFRESH_BURST_EN to drain a refresh backlog back-to-back instead of one refresh per interval.
module sdram_refresh_sched #(
  parameter int REF_INTERVAL  = 195,
  parameter int MAX_PENDING   = 8,
  parameter int URGENT_THRESH = 6
) (
  input  logic                  CLK,
  input  logic                  RESET,
  sdram_refresh_sched_if.master bus,
  output logic [1:0]            state_dbg
);

  localparam int            CW       = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CW-1:0] RELOAD   = CW'(REF_INTERVAL - 1);
  localparam logic [3:0]    PEND_MAX = 4'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] interval_cnt;
  logic          eligible;
  logic          tick;
  logic          ack_ok;
  logic          burst_go;
  logic [3:0]    pending_nxt;

  // A tick and an accepted ack in the same cycle cancel; a tick at the cap is lost.
  always_comb begin
    tick        = bus.init_done && (interval_cnt == '0);
    ack_ok      = bus.ref_ack && bus.ref_req && (bus.pending != 4'd0);
    pending_nxt = bus.pending;
    if (tick && !ack_ok) begin
      if (bus.pending != PEND_MAX) pending_nxt = bus.pending + 4'd1;
    end else if (ack_ok && !tick) begin
      pending_nxt = bus.pending - 4'd1;
    end
  end

`ifdef REFRESH_BURST_EN
  assign burst_go = (bus.pending != 4'd0) && !bus.ram_cycle;
`else
  assign burst_go = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      bus.ref_req    <= 1'b0;
      bus.ref_urgent <= 1'b0;
      bus.pending    <= 4'd0;
      bus.overflow   <= 1'b0;
      eligible       <= 1'b0;
      interval_cnt   <= RELOAD;
    end else begin
      if (!bus.init_done || tick) interval_cnt <= RELOAD;
      else                        interval_cnt <= interval_cnt - CW'(1);

      bus.pending    <= pending_nxt;
      bus.ref_urgent <= ({28'd0, pending_nxt} >= 32'(URGENT_THRESH));
      if (tick && !ack_ok && (bus.pending == PEND_MAX)) bus.overflow <= 1'b1;

      // A fresh tick re-arms non-urgent requests even if an ack lands in the same cycle.
      if (tick)        eligible <= 1'b1;
      else if (ack_ok) eligible <= 1'b0;

      case (state)
        IDLE: begin
          if ((bus.pending != 4'd0) &&
              (bus.ref_urgent || (!bus.ram_cycle && bus.cmd_idle && eligible))) begin
            state       <= REQ;
            bus.ref_req <= 1'b1;
          end
        end
        REQ: begin
          if (bus.ref_ack) begin
            state       <= WAIT;
            bus.ref_req <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.cmd_idle) begin
            if (burst_go) begin
              state       <= REQ;
              bus.ref_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          bus.ref_req <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
